// File: rtl/vector_store_unit.sv
// vector_store_unit: store-side sequencer that writes one OBI word per vector element.
// Ports:
//   clk, n_reset                 clock, asynchronous active-low reset
//   start_i, vl_i, vsew_i        launch (sampled in IDLE), element count, element width
//   strided_i, stride_i          strided addressing select and byte stride
//   base_addr_i, vs_addr_i       element-0 byte address, first source register
//   ready_o, done_o, err_o       idle flag, end-of-store pulse, abort pulse
//   vs_raddr_o, vs_rdata_i       register file read port (combinational data)
//   data_*                       OBI data master (write-only use)
module vector_store_unit (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start_i,
  input  logic [4:0]   vl_i,
  input  logic [1:0]   vsew_i,
  input  logic         strided_i,
  input  logic [31:0]  base_addr_i,
  input  logic [31:0]  stride_i,
  input  logic [4:0]   vs_addr_i,
  output logic         ready_o,
  output logic         done_o,
  output logic         err_o,
  output logic [4:0]   vs_raddr_o,
  input  logic [127:0] vs_rdata_i,
  output logic         data_req_o,
  input  logic         data_gnt_i,
  input  logic         data_rvalid_i,
  output logic [31:0]  data_addr_o,
  output logic         data_we_o,
  output logic [3:0]   data_be_o,
  output logic [31:0]  data_wdata_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state;
  logic [4:0] vl, vs_addr, idx, idx_nxt;
  logic [1:0] vsew;
  logic [31:0] addr, stride, addr_nxt, elem, mask;
  logic [3:0] off;
  logic err, start_bad;
  // an element straddling a word boundary cannot be expressed in one OBI beat
  function automatic logic misaligned(input logic [1:0] lane, input logic [1:0] sew);
    return ({1'b0, lane} + (3'd1 << sew)) > 3'd4;
  endfunction
  assign idx_nxt = idx + 5'd1;
  assign addr_nxt = addr + stride;
  assign start_bad = vsew_i == 2'b11 || misaligned(base_addr_i[1:0], vsew_i);
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      vl <= '0;
      vsew <= '0;
      vs_addr <= '0;
      addr <= '0;
      stride <= '0;
      idx <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          vl <= vl_i;
          vsew <= vsew_i;
          vs_addr <= vs_addr_i;
          addr <= base_addr_i;
          stride <= strided_i ? stride_i : 32'd1 << vsew_i;
          idx <= '0;
          err <= vsew_i == 2'b11 || (vl_i != 5'd0 && start_bad);
          state <= (vl_i == 5'd0 || start_bad) ? DONE : REQ;
        end
        REQ: if (data_gnt_i) state <= RESP;
        RESP: if (data_rvalid_i) begin
          idx <= idx_nxt;
          addr <= addr_nxt;
          if (idx_nxt == vl) state <= DONE;
          else if (misaligned(addr_nxt[1:0], vsew)) begin
            err <= 1'b1;
            state <= DONE;
          end else state <= REQ;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
  // byte offset of element idx inside its register: (idx mod 16>>vsew) << vsew
  assign off = (idx[3:0] & (4'hF >> vsew)) << vsew;
  assign elem = 32'(vs_rdata_i >> {off, 3'b000});
  assign mask = vsew == 2'd0 ? 32'h0000_00FF : vsew == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign ready_o = state == IDLE;
  assign done_o = state == DONE;
  assign err_o = done_o && err;
  assign data_req_o = state == REQ;
  assign data_we_o = data_req_o;
  assign data_addr_o = data_req_o ? {addr[31:2], 2'b00} : '0;
  assign data_be_o = data_req_o ? (vsew == 2'd0 ? 4'b0001 : vsew == 2'd1 ? 4'b0011 : 4'b1111) << addr[1:0] : '0;
  assign data_wdata_o = data_req_o ? (elem & mask) << {addr[1:0], 3'b000} : '0;
  assign vs_raddr_o = data_req_o ? vs_addr + (idx >> (3'd4 - {1'b0, vsew})) : '0;
endmodule

// File: tb/tb_vector_store_unit.sv
// tb_vector_store_unit: directed scoreboard bench for vector_store_unit.
module tb_vector_store_unit;
  logic clk = 1'b0, n_reset = 1'b0, start_i = 1'b0, strided_i = 1'b0;
  logic [4:0] vl_i = '0, vs_addr_i = '0, vs_raddr_o;
  logic [1:0] vsew_i = '0;
  logic [31:0] base_addr_i = '0, stride_i = '0, data_addr_o, data_wdata_o;
  logic [127:0] vs_rdata_i;
  logic ready_o, done_o, err_o, data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [3:0] data_be_o;
  logic [127:0] regs [32];
  typedef struct packed {logic [31:0] a; logic [3:0] be; logic [31:0] d; logic [4:0] r;} wr_t;
  wr_t wq[$];
  bit dq[$];
  wr_t e;
  bit ex, outs, prev_req, prev_gnt, pend;
  logic [67:0] prev_bus;
  int nvec = 0, nerr = 0, gx = 0, rx = 0, gcnt = 0, rcnt = 0;

  vector_store_unit dut (
    .clk(clk), .n_reset(n_reset), .start_i(start_i), .vl_i(vl_i), .vsew_i(vsew_i),
    .strided_i(strided_i), .base_addr_i(base_addr_i), .stride_i(stride_i), .vs_addr_i(vs_addr_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .vs_raddr_o(vs_raddr_o), .vs_rdata_i(vs_rdata_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o)
  );

  always #5 clk = ~clk;
  assign vs_rdata_i = regs[vs_raddr_o];

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pw(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input logic [4:0] r);
    wq.push_back({a, be, d, r});
  endtask

  // OBI slave: grant after gx extra REQ cycles, respond after rx extra RESP cycles
  initial begin
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (!n_reset) begin
        pend = 1'b0;
        gcnt = 0;
        rcnt = 0;
      end else if (pend) begin
        if (rcnt == rx) begin
          data_rvalid_i = 1'b1;
          pend = 1'b0;
          rcnt = 0;
        end else rcnt++;
      end else if (data_req_o) begin
        if (gcnt == gx) begin
          data_gnt_i = 1'b1;
          pend = 1'b1;
          gcnt = 0;
        end else gcnt++;
      end
    end
  end

  // monitor: pops expected writes on each accepted request and expected err on each done
  initial begin
    outs = 1'b0;
    prev_req = 1'b0;
    prev_gnt = 1'b0;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      if (!n_reset) begin
        outs = 1'b0;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
      end else begin
        if (data_req_o) begin
          chk(!outs && data_we_o === 1'b1, "req_overlap_we", 128'({outs, data_we_o}), 128'(2'b01));
          if (prev_req && !prev_gnt)
            chk({data_addr_o, data_be_o, data_wdata_o} === prev_bus, "req_stable",
                128'({data_addr_o, data_be_o, data_wdata_o}), 128'(prev_bus));
          if (data_gnt_i) begin
            if (wq.size() == 0) chk(1'b0, "unexpected_write", 128'({data_addr_o, data_be_o, data_wdata_o}), 128'(0));
            else begin
              e = wq.pop_front();
              chk({data_addr_o, data_be_o, data_wdata_o, vs_raddr_o} === e, "write_addr_be_wdata_raddr",
                  128'({data_addr_o, data_be_o, data_wdata_o, vs_raddr_o}), 128'(e));
            end
            outs = 1'b1;
          end
        end
        if (data_rvalid_i) outs = 1'b0;
        if (done_o) begin
          if (dq.size() == 0) chk(1'b0, "unexpected_done", 128'(1), 128'(0));
          else begin
            ex = dq.pop_front();
            chk(err_o === ex, "done_err", 128'(err_o), 128'(ex));
          end
        end else if (err_o) chk(1'b0, "err_without_done", 128'(1), 128'(0));
        prev_req = data_req_o;
        prev_gnt = data_gnt_i;
        prev_bus = {data_addr_o, data_be_o, data_wdata_o};
      end
    end
  end

  task automatic launch(input logic [4:0] vl, input logic [1:0] sew, input logic st,
                        input logic [31:0] base, input logic [31:0] stride, input logic [4:0] vs);
    @(negedge clk);
    chk(ready_o === 1'b1, "ready_before_start", 128'(ready_o), 128'(1));
    vl_i = vl;
    vsew_i = sew;
    strided_i = st;
    base_addr_i = base;
    stride_i = stride;
    vs_addr_i = vs;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // n counts negedges since the start cycle; done at start+n
  task automatic wait_done(input int exp_n, input int n0);
    int n = n0;
    while (!done_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(done_o === 1'b1 && n == exp_n, "done_latency", 128'(n), 128'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 16; k++) regs[r][8*k +: 8] = 8'((r - 8) * 16 + k);
    #2;
    chk({ready_o, done_o, err_o, data_req_o, data_we_o, data_be_o, data_wdata_o, data_addr_o, vs_raddr_o}
        === {1'b1, 4'b0, 4'b0, 32'b0, 32'b0, 5'b0}, "reset_state",
        128'({ready_o, done_o, err_o, data_req_o, data_we_o, data_be_o, data_wdata_o, data_addr_o, vs_raddr_o}),
        128'({1'b1, 4'b0, 4'b0, 32'b0, 32'b0, 5'b0}));
    repeat (2) @(negedge clk);
    #2 n_reset = 1'b1;
    // unit stride SEW32
    pw(32'h100, 4'hF, 32'h03020100, 5'd8);
    pw(32'h104, 4'hF, 32'h07060504, 5'd8);
    pw(32'h108, 4'hF, 32'h0B0A0908, 5'd8);
    pw(32'h10C, 4'hF, 32'h0F0E0D0C, 5'd8);
    dq.push_back(1'b0);
    launch(5'd4, 2'b10, 1'b0, 32'h100, 32'h0, 5'd8);
    wait_done(9, 1);
    // SEW8 unit stride from an unaligned base, all elements in one register
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = 32'h203 + 32'(i);
      pw(a & ~32'h3, 4'b0001 << a[1:0], 32'(i) << (8 * a[1:0]), 5'd8);
    end
    dq.push_back(1'b0);
    launch(5'd16, 2'b00, 1'b0, 32'h203, 32'h0, 5'd8);
    wait_done(33, 1);
    // SEW16 vl=12 crosses into the next register at element 8
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [4:0] r;
      int b0;
      a = 32'h300 + 32'(2 * i);
      r = 5'(i >= 8 ? 9 : 8);
      b0 = (int'(r) - 8) * 16 + (i % 8) * 2;
      pw(a & ~32'h3, 4'b0011 << a[1:0], 32'({8'(b0 + 1), 8'(b0)}) << (8 * a[1:0]), r);
    end
    dq.push_back(1'b0);
    launch(5'd12, 2'b01, 1'b0, 32'h300, 32'h0, 5'd8);
    wait_done(25, 1);
    // negative stride, lanes 0 / 2 / 0
    pw(32'h40, 4'b0011, 32'h00001110, 5'd9);
    pw(32'h3C, 4'b1100, 32'h13120000, 5'd9);
    pw(32'h3C, 4'b0011, 32'h00001514, 5'd9);
    dq.push_back(1'b0);
    launch(5'd3, 2'b01, 1'b1, 32'h40, 32'hFFFF_FFFE, 5'd9);
    wait_done(7, 1);
    // misaligned first element: no request
    dq.push_back(1'b1);
    launch(5'd2, 2'b01, 1'b0, 32'h43, 32'h0, 5'd8);
    wait_done(1, 1);
    // second element misaligned after a stride of 2 at SEW32
    pw(32'h100, 4'hF, 32'h03020100, 5'd8);
    dq.push_back(1'b1);
    launch(5'd3, 2'b10, 1'b1, 32'h100, 32'h2, 5'd8);
    wait_done(3, 1);
    // handshake stalls: two extra grant and two extra response cycles
    gx = 2;
    rx = 2;
    pw(32'h0, 4'hF, 32'h23222120, 5'd10);
    pw(32'h4, 4'hF, 32'h27262524, 5'd10);
    dq.push_back(1'b0);
    launch(5'd2, 2'b10, 1'b0, 32'h0, 32'h0, 5'd10);
    wait_done(13, 1);
    gx = 0;
    rx = 0;
    // vl=0 and reserved SEW
    dq.push_back(1'b0);
    launch(5'd0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd8);
    wait_done(1, 1);
    dq.push_back(1'b1);
    launch(5'd4, 2'b11, 1'b0, 32'h100, 32'h0, 5'd8);
    wait_done(1, 1);
    // start pulsed mid-store and again in the DONE cycle: both ignored
    pw(32'h500, 4'hF, 32'h03020100, 5'd8);
    pw(32'h504, 4'hF, 32'h07060504, 5'd8);
    dq.push_back(1'b0);
    launch(5'd2, 2'b10, 1'b0, 32'h500, 32'h0, 5'd8);
    vl_i = 5'd1;
    vsew_i = 2'b00;
    base_addr_i = 32'h900;
    vs_addr_i = 5'd12;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    wait_done(5, 3);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(data_req_o === 1'b0 && ready_o === 1'b1, "start_in_done_ignored", 128'({data_req_o, ready_o}), 128'(2'b01));
      @(negedge clk);
    end
    // reset while a request is pending
    gx = 10;
    launch(5'd2, 2'b10, 1'b0, 32'h0, 32'h0, 5'd8);
    @(negedge clk);
    chk(data_req_o === 1'b1, "req_before_reset", 128'(data_req_o), 128'(1));
    #2 n_reset = 1'b0;
    #1 chk(data_req_o === 1'b0 && ready_o === 1'b1 && done_o === 1'b0, "async_reset_mid_req",
           128'({data_req_o, ready_o, done_o}), 128'(3'b010));
    @(negedge clk);
    #2 n_reset = 1'b1;
    gx = 0;
    repeat (4) @(negedge clk);
    chk(ready_o === 1'b1 && data_req_o === 1'b0, "idle_after_reset", 128'({ready_o, data_req_o}), 128'(2'b10));
    chk(wq.size() == 0 && dq.size() == 0, "queues_drained", 128'({wq.size(), dq.size()}), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
